// File: rtl/multi_slot_dispense_controller.sv
// Multi-slot vending dispense controller: reads slot stock from an external
// inventory RAM, drives the slot motor until the item leaves the sensor
// (with timed retries), then decrements stock and reports done or a fault.
module multi_slot_dispense_controller #(
  parameter int unsigned NUM_ITEMS     = 16,
  parameter int unsigned ITEM_W        = 4,
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned STOCK_W       = 16,
  parameter int unsigned DISPENSE_TIME = 50000000,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ITEM_W-1:0]    cmd_item,
  output logic [ADDR_W-1:0]    inv_addr,
  input  logic [STOCK_W-1:0]   inv_rd_data,
  output logic [STOCK_W-1:0]   inv_wr_data,
  output logic                 inv_we,
  input  logic [NUM_ITEMS-1:0] item_sensors,
  output logic [NUM_ITEMS-1:0] dispense_motors,
  output logic                 busy,
  output logic [ITEM_W-1:0]    current_item,
  output logic                 done,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [15:0]          dispense_count
);

  localparam int unsigned TIMER_W = (DISPENSE_TIME > 1) ? $clog2(DISPENSE_TIME) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned CNT_W   = 16;

  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(DISPENSE_TIME - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_OUT_OF_STOCK = 3'd1;
  localparam logic [2:0] ERR_NO_ITEM      = 3'd2;
  localparam logic [2:0] ERR_JAM          = 3'd3;
  localparam logic [2:0] ERR_BAD_ITEM     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    CHECK   = 3'd2,
    DRIVE   = 3'd3,
    UPDATE  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t               state_q, state_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic [RETRY_W-1:0]   retry_q, retry_n;
  logic [STOCK_W-1:0]   stock_q, stock_n;

  logic [ITEM_W-1:0]    current_item_n;
  logic [ADDR_W-1:0]    inv_addr_n;
  logic [STOCK_W-1:0]   inv_wr_data_n;
  logic                 inv_we_n;
  logic [NUM_ITEMS-1:0] motors_n;
  logic                 cmd_ready_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 err_valid_n;
  logic [2:0]           err_code_n;
  logic [CNT_W-1:0]     count_n;

  logic [NUM_ITEMS-1:0] item_onehot_c;
  logic                 item_present_c;
  logic                 cmd_item_bad_c;

  // One-hot slot select and sensor lookup for the latched item
  always_comb begin
    item_onehot_c  = NUM_ITEMS'(1) << current_item;
    item_present_c = |(item_sensors & item_onehot_c);
    cmd_item_bad_c = 32'(cmd_item) >= NUM_ITEMS;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n        = state_q;
    timer_n        = timer_q;
    retry_n        = retry_q;
    stock_n        = stock_q;
    current_item_n = current_item;
    inv_addr_n     = inv_addr;
    inv_wr_data_n  = inv_wr_data;
    err_code_n     = err_code;
    count_n        = dispense_count;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          current_item_n = cmd_item;
          inv_addr_n     = ADDR_W'(cmd_item);
          err_code_n     = ERR_NONE;
          timer_n        = '0;
          retry_n        = '0;
          if (cmd_item_bad_c) begin
            state_n    = FAULT;
            err_code_n = ERR_BAD_ITEM;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_n = CHECK;
      CHECK: begin
        stock_n = inv_rd_data;
        if (inv_rd_data == '0) begin
          state_n    = FAULT;
          err_code_n = ERR_OUT_OF_STOCK;
        end else if (!item_present_c) begin
          state_n    = FAULT;
          err_code_n = ERR_NO_ITEM;
        end else begin
          state_n = DRIVE;
          timer_n = '0;
        end
      end
      DRIVE: begin
        // Item leaving the slot wins over a coincident timeout
        if (!item_present_c) begin
          state_n       = UPDATE;
          inv_addr_n    = ADDR_W'(current_item);
          inv_wr_data_n = stock_q - STOCK_W'(1);
          count_n       = dispense_count + CNT_W'(1);
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_n = retry_q + RETRY_W'(1);
            timer_n = '0;
          end else begin
            state_n    = FAULT;
            err_code_n = ERR_JAM;
          end
        end else begin
          timer_n = timer_q + TIMER_W'(1);
        end
      end
      UPDATE:  state_n = IDLE;
      FAULT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    motors_n    = (state_n == DRIVE) ? item_onehot_c : '0;
    inv_we_n    = (state_n == UPDATE);
    done_n      = (state_n == UPDATE);
    err_valid_n = (state_n == FAULT);
    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      retry_q         <= '0;
      stock_q         <= '0;
      current_item    <= '0;
      inv_addr        <= '0;
      inv_wr_data     <= '0;
      inv_we          <= 1'b0;
      dispense_motors <= '0;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_valid       <= 1'b0;
      err_code        <= ERR_NONE;
      dispense_count  <= '0;
    end else begin
      state_q         <= state_n;
      timer_q         <= timer_n;
      retry_q         <= retry_n;
      stock_q         <= stock_n;
      current_item    <= current_item_n;
      inv_addr        <= inv_addr_n;
      inv_wr_data     <= inv_wr_data_n;
      inv_we          <= inv_we_n;
      dispense_motors <= motors_n;
      cmd_ready       <= cmd_ready_n;
      busy            <= busy_n;
      done            <= done_n;
      err_valid       <= err_valid_n;
      err_code        <= err_code_n;
      dispense_count  <= count_n;
    end
  end

endmodule

// File: tb/tb_multi_slot_dispense_controller.sv
// Directed bench for multi_slot_dispense_controller with an inventory RAM model.
module tb_multi_slot_dispense_controller;

  localparam int unsigned NUM_ITEMS = 12;
  localparam int unsigned ITEM_W    = 4;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned STOCK_W   = 16;

  logic                 clk;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ITEM_W-1:0]    cmd_item;
  logic [ADDR_W-1:0]    inv_addr;
  logic [STOCK_W-1:0]   inv_rd_data;
  logic [STOCK_W-1:0]   inv_wr_data;
  logic                 inv_we;
  logic [NUM_ITEMS-1:0] item_sensors;
  logic [NUM_ITEMS-1:0] dispense_motors;
  logic                 busy;
  logic [ITEM_W-1:0]    current_item;
  logic                 done;
  logic                 err_valid;
  logic [2:0]           err_code;
  logic [15:0]          dispense_count;

  logic                 pre_we;
  logic [ADDR_W-1:0]    pre_addr;
  logic [STOCK_W-1:0]   pre_data;
  logic [STOCK_W-1:0]   mem [256];

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int mot_cnt  = 0;
  int we_base;
  int mot_base;

  multi_slot_dispense_controller #(
    .NUM_ITEMS    (NUM_ITEMS),
    .ITEM_W       (ITEM_W),
    .ADDR_W       (ADDR_W),
    .STOCK_W      (STOCK_W),
    .DISPENSE_TIME(8),
    .MAX_RETRY    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_item       (cmd_item),
    .inv_addr       (inv_addr),
    .inv_rd_data    (inv_rd_data),
    .inv_wr_data    (inv_wr_data),
    .inv_we         (inv_we),
    .item_sensors   (item_sensors),
    .dispense_motors(dispense_motors),
    .busy           (busy),
    .current_item   (current_item),
    .done           (done),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .dispense_count (dispense_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read inventory RAM plus write and motor-on cycle counters
  always @(posedge clk) begin
    inv_rd_data <= mem[inv_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (inv_we) mem[inv_addr] <= inv_wr_data;
    if (inv_we) we_cnt <= we_cnt + 1;
    if (|dispense_motors) mot_cnt <= mot_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [STOCK_W-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_item     = '0;
    item_sensors = '0;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    tick();
    preload(8'd3, 16'd5);
    preload(8'd5, 16'd0);
    preload(8'd2, 16'd1);
    preload(8'd7, 16'd3);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_motors", 32'(dispense_motors), 32'd0);
    check("rst_inv_we", 32'(inv_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_current_item", 32'(current_item), 32'd0);
    check("rst_inv_addr", 32'(inv_addr), 32'd0);
    check("rst_inv_wr_data", 32'(inv_wr_data), 32'd0);
    check("rst_count", 32'(dispense_count), 32'd0);

    rst          = 1'b0;
    item_sensors = 12'h0A8;  // slots 3, 5, 7 occupied; slot 2 empty
    tick();
    check("idle_ready", 32'(cmd_ready), 32'd1);

    // Successful dispense of slot 3, sensor clears after 4 drive cycles
    we_base  = we_cnt;
    mot_base = mot_cnt;
    cmd_valid = 1'b1;
    cmd_item  = 4'd3;
    tick();  // T+1
    cmd_valid = 1'b0;
    check("ok_t1_busy", 32'(busy), 32'd1);
    check("ok_t1_ready", 32'(cmd_ready), 32'd0);
    check("ok_t1_item", 32'(current_item), 32'd3);
    check("ok_t1_addr", 32'(inv_addr), 32'd3);
    check("ok_t1_motors", 32'(dispense_motors), 32'd0);
    tick();  // T+2
    check("ok_t2_motors", 32'(dispense_motors), 32'd0);
    tick();  // T+3
    check("ok_t3_motors", 32'(dispense_motors), 32'h008);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ok_drive_motors", 32'(dispense_motors), 32'h008);
    end
    item_sensors[3] = 1'b0;
    tick();  // T+7 UPDATE
    check("ok_done", 32'(done), 32'd1);
    check("ok_we", 32'(inv_we), 32'd1);
    check("ok_wr_addr", 32'(inv_addr), 32'd3);
    check("ok_wr_data", 32'(inv_wr_data), 32'd4);
    check("ok_upd_motors", 32'(dispense_motors), 32'd0);
    check("ok_count", 32'(dispense_count), 32'd1);
    tick();  // T+8
    check("ok_done_pulse", 32'(done), 32'd0);
    check("ok_we_pulse", 32'(inv_we), 32'd0);
    check("ok_back_idle", 32'(cmd_ready), 32'd1);
    check("ok_mem3", 32'(mem[3]), 32'd4);
    check("ok_we_count", 32'(we_cnt - we_base), 32'd1);
    check("ok_motor_cycles", 32'(mot_cnt - mot_base), 32'd4);

    // Out of stock on slot 5
    we_base  = we_cnt;
    mot_base = mot_cnt;
    cmd_valid = 1'b1;
    cmd_item  = 4'd5;
    tick();  // T+1
    cmd_valid = 1'b0;
    tick();  // T+2
    check("oos_t2_err_valid", 32'(err_valid), 32'd0);
    tick();  // T+3
    check("oos_err_valid", 32'(err_valid), 32'd1);
    check("oos_err_code", 32'(err_code), 32'd1);
    check("oos_motors", 32'(dispense_motors), 32'd0);
    tick();  // T+4
    check("oos_err_pulse", 32'(err_valid), 32'd0);
    check("oos_code_held", 32'(err_code), 32'd1);
    check("oos_ready", 32'(cmd_ready), 32'd1);
    check("oos_no_motor", 32'(mot_cnt - mot_base), 32'd0);
    check("oos_no_we", 32'(we_cnt - we_base), 32'd0);

    // Stock present but slot 2 sensor empty
    we_base  = we_cnt;
    mot_base = mot_cnt;
    cmd_valid = 1'b1;
    cmd_item  = 4'd2;
    tick();  // T+1
    cmd_valid = 1'b0;
    check("noitem_code_cleared", 32'(err_code), 32'd0);
    tick();
    tick();  // T+3
    check("noitem_err_valid", 32'(err_valid), 32'd1);
    check("noitem_err_code", 32'(err_code), 32'd2);
    tick();
    check("noitem_no_motor", 32'(mot_cnt - mot_base), 32'd0);
    check("noitem_no_we", 32'(we_cnt - we_base), 32'd0);

    // Jam on slot 7: three 8-cycle attempts then fault
    we_base  = we_cnt;
    mot_base = mot_cnt;
    cmd_valid = 1'b1;
    cmd_item  = 4'd7;
    tick();  // T+1
    cmd_valid = 1'b0;
    repeat (25) tick();  // T+26, last drive cycle
    check("jam_last_drive", 32'(dispense_motors), 32'h080);
    check("jam_busy", 32'(busy), 32'd1);
    tick();  // T+27
    check("jam_err_valid", 32'(err_valid), 32'd1);
    check("jam_err_code", 32'(err_code), 32'd3);
    check("jam_motors_off", 32'(dispense_motors), 32'd0);
    check("jam_motor_cycles", 32'(mot_cnt - mot_base), 32'd24);
    check("jam_no_we", 32'(we_cnt - we_base), 32'd0);
    tick();
    check("jam_ready", 32'(cmd_ready), 32'd1);
    check("jam_count", 32'(dispense_count), 32'd1);

    // Out-of-range slot index
    we_base = we_cnt;
    cmd_valid = 1'b1;
    cmd_item  = 4'd15;
    tick();  // T+1
    cmd_valid = 1'b0;
    check("bad_err_valid", 32'(err_valid), 32'd1);
    check("bad_err_code", 32'(err_code), 32'd4);
    check("bad_busy", 32'(busy), 32'd1);
    check("bad_motors", 32'(dispense_motors), 32'd0);
    tick();
    check("bad_ready", 32'(cmd_ready), 32'd1);
    check("bad_code_held", 32'(err_code), 32'd4);
    check("bad_no_we", 32'(we_cnt - we_base), 32'd0);

    // Command while busy is ignored; reset mid-drive stops the motor
    we_base = we_cnt;
    item_sensors[3] = 1'b1;
    cmd_valid = 1'b1;
    cmd_item  = 4'd3;
    tick();  // T+1
    cmd_item  = 4'd7;
    check("busy_item_t1", 32'(current_item), 32'd3);
    tick();  // T+2
    cmd_valid = 1'b0;
    check("busy_item_t2", 32'(current_item), 32'd3);
    tick();  // T+3
    check("rstd_motor_on", 32'(dispense_motors), 32'h008);
    tick();  // T+4
    check("rstd_motor_on2", 32'(dispense_motors), 32'h008);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_motors", 32'(dispense_motors), 32'd0);
    check("rstd_ready", 32'(cmd_ready), 32'd1);
    check("rstd_busy", 32'(busy), 32'd0);
    check("rstd_count", 32'(dispense_count), 32'd0);
    check("rstd_err_code", 32'(err_code), 32'd0);
    check("rstd_item", 32'(current_item), 32'd0);
    check("rstd_addr", 32'(inv_addr), 32'd0);
    check("rstd_wr_data", 32'(inv_wr_data), 32'd0);
    check("rstd_we", 32'(inv_we), 32'd0);
    tick();
    check("rstd_idle", 32'(cmd_ready), 32'd1);
    check("rstd_motor_idle", 32'(dispense_motors), 32'd0);
    check("rstd_mem3", 32'(mem[3]), 32'd4);
    check("rstd_no_we", 32'(we_cnt - we_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
